// File: rtl/alu_share_ctrl.sv
// Shares one execute ALU between the pipeline (requester 0) and the scan port
// (requester 1); owns a one-entry response buffer and the Z/V/N flag register.
module alu_share_ctrl #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovfl,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [2:0]        flag
);

    // Handshake: a request moves on a rising edge where req_valid[i] & req_ready[i];
    // a response drains on an edge where rsp_valid[i] & rsp_ready[i]. Valid never
    // depends on ready on the same side, and a held response does not change until drained.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, state_nxt;
    logic   owner;
    logic   last_grant;
    logic   eligible;
    logic   grant_vld;
    logic   grant_id;
    logic   z_en;
    logic   vn_en;

    always_comb begin
        eligible = (state == EMPTY) || rsp_ready[owner];
        if (req_valid == 2'b11) begin
            grant_id = RR_EN ? ~last_grant : 1'b0;
        end else begin
            grant_id = req_valid[1];
        end
        grant_vld = rst_n && eligible && (req_valid != 2'b00);
        req_ready = 2'b00;
        if (grant_vld) begin
            req_ready[grant_id] = 1'b1;
        end
        alu_op = req0_op;
        alu_a  = req0_a;
        alu_b  = req0_b;
        if (grant_vld && grant_id) begin
            alu_op = req1_op;
            alu_a  = req1_a;
            alu_b  = req1_b;
        end
        z_en  = (alu_op <= OP_W'(2)) || ((alu_op >= OP_W'(4)) && (alu_op <= OP_W'(6)));
        vn_en = (alu_op <= OP_W'(1));
    end

    // A new accept wins over a drain, so drain+accept keeps the buffer FULL.
    always_comb begin
        state_nxt = state;
        if (grant_vld) begin
            state_nxt = FULL;
        end else if ((state == FULL) && rsp_ready[owner]) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data   <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            flag       <= 3'b000;
        end else if (grant_vld) begin
            rsp_data   <= alu_result;
            owner      <= grant_id;
            last_grant <= grant_id;
            if (z_en) begin
                flag[0] <= (alu_result == '0);
            end
            if (vn_en) begin
                flag[1] <= alu_ovfl;
                flag[2] <= alu_result[DATA_W-1];
            end
        end
    end

    assign rsp_valid = (state == FULL) ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule
